// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: {rd,sel} register codes, reset constants and ExcCode values.
package cp0_regfile_pkg;

  localparam logic [7:0] CP0_BADVADDR = {5'd8, 3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9, 3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] CP0_PRID     = {5'd15, 3'd0};

  localparam logic [31:0] CP0_PRID_VALUE   = 32'h0000_4220;
  localparam logic [31:0] CP0_STATUS_RESET = 32'h0040_0000;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_MOD  = 5'h01,
    EXC_TLBL = 5'h02,
    EXC_TLBS = 5'h03,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_IBE  = 5'h06,
    EXC_DBE  = 5'h07,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0A,
    EXC_CPU  = 5'h0B,
    EXC_OV   = 5'h0C,
    EXC_TR   = 5'h0D
  } exc_code_e;

  function automatic logic [7:0] cp0_reg_addr(input logic [4:0] rd, input logic [2:0] sel);
    return {rd, sel};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every other clock, TI latches on a Count/Compare match.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic toggle;

  // A Count write wins over the increment; a Compare write wins over a same-cycle match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      toggle  <= 1'b0;
      count   <= 32'h0;
      compare <= 32'h0;
      ti      <= 1'b0;
    end else begin
      toggle <= ~toggle;
      if (count_we)
        count <= wdata;
      else if (toggle)
        count <= count + 32'd1;

      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (count == compare) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS-style CP0 register file: Status/Cause/EPC/BadVAddr/PRId plus the Count/Compare timer.
module cp0_regfile
  import cp0_regfile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cp0_we,
  input  logic [7:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] exc_pc,
  input  logic        exc_bd,
  input  logic        exc_badvaddr_we,
  input  logic [31:0] exc_badvaddr,
  input  logic        eret_valid,
  input  logic [5:0]  ext_int,
  output logic [31:0] epc,
  output logic        status_exl,
  output logic        int_req
);

  logic [7:0]  status_im;
  logic        status_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip_hw;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;
  logic [31:0] status_word;
  logic [31:0] cause_word;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;

  assign wr_count   = cp0_we && (cp0_addr == CP0_COUNT);
  assign wr_compare = cp0_we && (cp0_addr == CP0_COMPARE);
  assign wr_status  = cp0_we && (cp0_addr == CP0_STATUS);
  assign wr_cause   = cp0_we && (cp0_addr == CP0_CAUSE);
  assign wr_epc     = cp0_we && (cp0_addr == CP0_EPC);

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // EXL arbitration: exception sets it, ERET clears it, a software write only when neither fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      status_im  <= 8'h0;
      status_ie  <= 1'b0;
      status_exl <= 1'b0;
    end else begin
      if (wr_status) begin
        status_im <= cp0_wdata[15:8];
        status_ie <= cp0_wdata[0];
      end
      if (exc_valid)
        status_exl <= 1'b1;
      else if (eret_valid)
        status_exl <= 1'b0;
      else if (wr_status)
        status_exl <= cp0_wdata[1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_bd    <= 1'b0;
      cause_ip_hw <= 6'h0;
      cause_ip_sw <= 2'h0;
      cause_exc   <= 5'h0;
    end else begin
      cause_ip_hw <= {ext_int[5] | ti, ext_int[4:0]};
      if (wr_cause)
        cause_ip_sw <= cp0_wdata[9:8];
      if (exc_valid) begin
        cause_exc <= exc_code;
        if (!status_exl)
          cause_bd <= exc_bd;
      end
    end
  end

  // A nested exception (EXL already set) leaves EPC alone, so the software write may land.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc      <= 32'h0;
      badvaddr <= 32'h0;
    end else begin
      if (exc_valid && !status_exl)
        epc <= exc_bd ? (exc_pc - 32'd4) : exc_pc;
      else if (wr_epc)
        epc <= cp0_wdata;
      if (exc_valid && exc_badvaddr_we)
        badvaddr <= exc_badvaddr;
    end
  end

  assign status_word = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
  assign cause_word  = {cause_bd, ti, 14'b0, cause_ip_hw, cause_ip_sw, 1'b0, cause_exc, 2'b0};

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_addr)
      CP0_BADVADDR: cp0_rdata = badvaddr;
      CP0_COUNT:    cp0_rdata = count;
      CP0_COMPARE:  cp0_rdata = compare;
      CP0_STATUS:   cp0_rdata = status_word;
      CP0_CAUSE:    cp0_rdata = cause_word;
      CP0_EPC:      cp0_rdata = epc;
      CP0_PRID:     cp0_rdata = CP0_PRID_VALUE;
      default:      cp0_rdata = 32'h0;
    endcase
  end

  assign int_req = status_ie & ~status_exl & (|({cause_ip_hw, cause_ip_sw} & status_im));

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: register table, timer, exception and reset sequences.
module tb_cp0_regfile;
  import cp0_regfile_pkg::*;

  logic        clk;
  logic        reset;
  logic        cp0_we;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        exc_badvaddr_we;
  logic [31:0] exc_badvaddr;
  logic        eret_valid;
  logic [5:0]  ext_int;
  logic [31:0] epc;
  logic        status_exl;
  logic        int_req;

  localparam int SIG_EPC = 0;
  localparam int SIG_EXL = 1;
  localparam int SIG_INT = 2;

  typedef struct {
    string       name;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] pre_exp;
    logic [31:0] post_exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_item_t;

  vec_t     vecs[$];
  sb_item_t sb_q[$];
  int       n_vec;
  int       n_miss;

  cp0_regfile dut (
    .clk             (clk),
    .reset           (reset),
    .cp0_we          (cp0_we),
    .cp0_addr        (cp0_addr),
    .cp0_wdata       (cp0_wdata),
    .cp0_rdata       (cp0_rdata),
    .exc_valid       (exc_valid),
    .exc_code        (exc_code),
    .exc_pc          (exc_pc),
    .exc_bd          (exc_bd),
    .exc_badvaddr_we (exc_badvaddr_we),
    .exc_badvaddr    (exc_badvaddr),
    .eret_valid      (eret_valid),
    .ext_int         (ext_int),
    .epc             (epc),
    .status_exl      (status_exl),
    .int_req         (int_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic push_exp(input string n, input logic [31:0] e);
    sb_item_t it;
    it.name = n;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  task automatic checkOutput(input logic [31:0] actual);
    sb_item_t it;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $display("[TB] FAIL sb_empty: got 0x%08h with no expected value queued", actual);
    end else begin
      it = sb_q.pop_front();
      if (actual !== it.exp) begin
        n_miss++;
        $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", it.name, actual, it.exp);
      end
    end
  endtask

  task automatic expectRead(input string n, input logic [7:0] a, input logic [31:0] e);
    cp0_addr = a;
    push_exp(n, e);
    #1;
    checkOutput(cp0_rdata);
  endtask

  task automatic expectSig(input string n, input int which, input logic [31:0] e);
    push_exp(n, e);
    #1;
    case (which)
      SIG_EPC: checkOutput(epc);
      SIG_EXL: checkOutput({31'b0, status_exl});
      default: checkOutput({31'b0, int_req});
    endcase
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                       input logic ev, input logic [4:0] code, input logic [31:0] pc,
                       input logic bd, input logic bvwe, input logic [31:0] bv, input logic er);
    @(negedge clk);
    cp0_we          = we;
    cp0_addr        = addr;
    cp0_wdata       = wdata;
    exc_valid       = ev;
    exc_code        = code;
    exc_pc          = pc;
    exc_bd          = bd;
    exc_badvaddr_we = bvwe;
    exc_badvaddr    = bv;
    eret_valid      = er;
    @(posedge clk);
    #1;
    cp0_we          = 1'b0;
    exc_valid       = 1'b0;
    exc_badvaddr_we = 1'b0;
    eret_valid      = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    cycle(1'b1, addr, data, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Write cycle: the read during the write sees the old value, the read after the edge the new one.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    cp0_we    = v.we;
    cp0_addr  = v.addr;
    cp0_wdata = v.wdata;
    push_exp({v.name, "_pre"}, v.pre_exp);
    #1;
    checkOutput(cp0_rdata);
    @(posedge clk);
    #1;
    cp0_we = 1'b0;
    push_exp(v.name, v.post_exp);
    #1;
    checkOutput(cp0_rdata);
  endtask

  initial begin
    n_vec           = 0;
    n_miss          = 0;
    reset           = 1'b0;
    cp0_we          = 1'b0;
    cp0_addr        = 8'h0;
    cp0_wdata       = 32'h0;
    exc_valid       = 1'b0;
    exc_code        = 5'h0;
    exc_pc          = 32'h0;
    exc_bd          = 1'b0;
    exc_badvaddr_we = 1'b0;
    exc_badvaddr    = 32'h0;
    eret_valid      = 1'b0;
    ext_int         = 6'h0;

    #2;
    expectRead("rst_status", CP0_STATUS, CP0_STATUS_RESET);
    expectRead("rst_prid", CP0_PRID, 32'h0000_4220);
    expectRead("rst_count", CP0_COUNT, 32'h0);
    expectSig("rst_epc", SIG_EPC, 32'h0);
    expectSig("rst_exl", SIG_EXL, 32'h0);
    expectSig("rst_int_req", SIG_INT, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    vecs.push_back('{"compare_wr", 1'b1, CP0_COMPARE, 32'h8000_0000, 32'h0, 32'h8000_0000});
    vecs.push_back('{"status_ff01", 1'b1, CP0_STATUS, 32'h0000_FF01, 32'h0040_0000, 32'h0040_FF01});
    vecs.push_back('{"unmapped_3_0", 1'b1, cp0_reg_addr(5'd3, 3'd0), 32'hFFFF_FFFF, 32'h0, 32'h0});
    vecs.push_back('{"cause_sw_ip", 1'b1, CP0_CAUSE, 32'hFFFF_FFFF, 32'h0, 32'h0000_0300});
    vecs.push_back('{"status_all1", 1'b1, CP0_STATUS, 32'hFFFF_FFFF, 32'h0040_FF01, 32'h0040_FF03});
    vecs.push_back('{"status_zero", 1'b1, CP0_STATUS, 32'h0, 32'h0040_FF03, 32'h0040_0000});
    vecs.push_back('{"cause_clear", 1'b1, CP0_CAUSE, 32'h0, 32'h0000_0300, 32'h0});
    vecs.push_back('{"epc_wr", 1'b1, CP0_EPC, 32'hA5A5_5A5A, 32'h0, 32'hA5A5_5A5A});
    vecs.push_back('{"prid_ro", 1'b1, CP0_PRID, 32'h0, 32'h0000_4220, 32'h0000_4220});
    vecs.push_back('{"badvaddr_ro", 1'b1, CP0_BADVADDR, 32'h0000_1234, 32'h0, 32'h0});
    vecs.push_back('{"epc_sel1", 1'b1, cp0_reg_addr(5'd14, 3'd1), 32'h0000_FFFF, 32'h0, 32'h0});
    vecs.push_back('{"epc_hold", 1'b0, CP0_EPC, 32'h0, 32'hA5A5_5A5A, 32'hA5A5_5A5A});
    vecs.push_back('{"compare_wr1", 1'b1, CP0_COMPARE, 32'h1, 32'h8000_0000, 32'h1});
    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i]);

    // Timer: Compare=10, Count=8, then TI and int_req once Count reaches 10.
    reset_dut();
    wr(CP0_STATUS, 32'h0000_8001);
    wr(CP0_COUNT, 32'h0);
    wr(CP0_COMPARE, 32'd10);
    wr(CP0_COUNT, 32'd8);
    waitEdges(2);
    expectRead("tmr_count9", CP0_COUNT, 32'd9);
    expectRead("tmr_cause_idle", CP0_CAUSE, 32'h0);
    expectSig("tmr_int_idle", SIG_INT, 32'h0);
    waitEdges(5);
    expectRead("tmr_cause_ti", CP0_CAUSE, 32'h4000_8000);
    expectSig("tmr_int_req", SIG_INT, 32'h1);
    wr(CP0_COMPARE, 32'd20);
    expectRead("tmr_ti_clear", CP0_CAUSE, 32'h0000_8000);
    waitEdges(2);
    expectRead("tmr_ip_clear", CP0_CAUSE, 32'h0);
    expectSig("tmr_int_clear", SIG_INT, 32'h0);
    @(negedge clk);
    ext_int = 6'b100001;
    waitEdges(1);
    expectRead("ext_int_ip", CP0_CAUSE, 32'h0000_8400);
    expectSig("ext_int_req", SIG_INT, 32'h1);
    @(negedge clk);
    ext_int = 6'h0;
    waitEdges(1);
    expectRead("ext_int_clear", CP0_CAUSE, 32'h0);

    // Exceptions, nesting, ERET and same-cycle priority.
    reset_dut();
    wr(CP0_COMPARE, 32'h8000_0000);
    waitEdges(1);
    cycle(1'b0, 8'h0, 32'h0, 1'b1, EXC_ADEL, 32'hBFC0_0100, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    expectSig("exc1_epc", SIG_EPC, 32'hBFC0_00FC);
    expectSig("exc1_exl", SIG_EXL, 32'h1);
    expectRead("exc1_cause", CP0_CAUSE, 32'h8000_0010);
    expectRead("exc1_badvaddr", CP0_BADVADDR, 32'hDEAD_BEEF);
    expectRead("exc1_status", CP0_STATUS, 32'h0040_0002);
    cycle(1'b0, 8'h0, 32'h0, 1'b1, EXC_OV, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b0);
    expectSig("exc2_epc_hold", SIG_EPC, 32'hBFC0_00FC);
    expectRead("exc2_cause", CP0_CAUSE, 32'h8000_0030);
    expectRead("exc2_badvaddr", CP0_BADVADDR, 32'hDEAD_BEEF);
    cycle(1'b0, 8'h0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    expectSig("eret_exl", SIG_EXL, 32'h0);
    expectRead("eret_status", CP0_STATUS, 32'h0040_0000);
    cycle(1'b1, CP0_EPC, 32'h0000_1234, 1'b1, EXC_SYS, 32'h0000_2000, 1'b0, 1'b0, 32'h0, 1'b0);
    expectSig("exc_vs_wr_epc", SIG_EPC, 32'h0000_2000);
    expectRead("exc3_cause", CP0_CAUSE, 32'h0000_0020);
    cycle(1'b1, CP0_STATUS, 32'h0000_0303, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    expectRead("eret_vs_wr_status", CP0_STATUS, 32'h0040_0301);
    expectSig("eret_vs_wr_exl", SIG_EXL, 32'h0);

    // Count wrap, then an asynchronous reset in the middle of a write and an exception.
    wr(CP0_COUNT, 32'hFFFF_FFFF);
    expectRead("count_load", CP0_COUNT, 32'hFFFF_FFFF);
    waitEdges(2);
    expectRead("count_wrap", CP0_COUNT, 32'h0);
    waitEdges(4);
    expectRead("count_run", CP0_COUNT, 32'h2);
    wr(CP0_STATUS, 32'h0000_FF01);
    @(negedge clk);
    cp0_we    = 1'b1;
    cp0_addr  = CP0_EPC;
    cp0_wdata = 32'h0000_CAFE;
    exc_valid = 1'b1;
    exc_pc    = 32'h0000_0100;
    exc_code  = EXC_RI;
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    expectSig("midrst_epc", SIG_EPC, 32'h0);
    expectSig("midrst_exl", SIG_EXL, 32'h0);
    expectSig("midrst_int", SIG_INT, 32'h0);
    cp0_we    = 1'b0;
    exc_valid = 1'b0;
    expectRead("midrst_count", CP0_COUNT, 32'h0);
    expectRead("midrst_status", CP0_STATUS, 32'h0040_0000);
    expectRead("midrst_cause", CP0_CAUSE, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    waitEdges(1);
    expectRead("postrst_epc", CP0_EPC, 32'h0);

    if (sb_q.size() != 0) begin
      n_miss++;
      $display("[TB] FAIL sb_leftover: got %0d unchecked entries, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
